jtgng_colmix_gen: RTL and testbench

JTGNG_COLMIX_GEN -- requirements
Module: jtgng_colmix_gen

---
 rtl/jtgng_colmix_gen.sv | 204 ++++++++++++++++++++
 tb/tb_jtgng_colmix_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_colmix_gen.sv
// Colour mixer: layer priority, palette lookup and frame-based fade.
// Four-stage cen pipeline from layer pixels to scaled RGB output.
module jtgng_colmix_gen #(
   parameter int LAYERS      = 4,
   parameter int LW          = 6,
   parameter int CW          = 4,
   parameter int SELW        = 2,
   parameter int FADE_FRAMES = 4
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cen,
   input  logic [LAYERS*LW-1:0] pxl,
   input  logic [LAYERS-1:0]    gfx_en,
   input  logic                 LHBL,
   input  logic                 LVBL,
   input  logic [7:0]           prog_addr,
   input  logic [1:0]           prog_sel,
   input  logic                 prog_we,
   input  logic [CW-1:0]        prog_din,
   input  logic                 fade_req,
   input  logic                 fade_dir,
   output logic                 fade_busy,
   output logic [CW-1:0]        red,
   output logic [CW-1:0]        green,
   output logic [CW-1:0]        blue,
   output logic                 LHBL_dly,
   output logic                 LVBL_dly
);

   localparam int IW  = $clog2(LAYERS);
   localparam int FCW = FADE_FRAMES > 1 ? $clog2(FADE_FRAMES) : 1;
   localparam int PW  = CW + 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OUT  = 2'd1;
   localparam logic [1:0] ST_DARK = 2'd2;
   localparam logic [1:0] ST_IN   = 2'd3;

   generate
      if (SELW + IW > CW || SELW + LW != 8) begin : g_bad_cfg
         $error("jtgng_colmix_gen: bad SELW/LW/CW/LAYERS mix");
      end
   endgenerate

   logic [CW-1:0] prom_r [256];
   logic [CW-1:0] prom_g [256];
   logic [CW-1:0] prom_b [256];
   logic [CW-1:0] prom_p [256];

   // PROMs are never reset so their contents survive rst_n
   always_ff @(posedge clk) begin
      if (prog_we) begin
         unique case (prog_sel)
            2'd0: prom_r[prog_addr] <= prog_din;
            2'd1: prom_g[prog_addr] <= prog_din;
            2'd2: prom_b[prog_addr] <= prog_din;
            2'd3: prom_p[prog_addr] <= prog_din;
         endcase
      end
   end

   logic [LAYERS-1:0] opaque;
   logic [7:0]        prio_addr;
   logic [CW-1:0]     prio_word;

   always_comb begin
      opaque = '0;
      for (int n = 0; n < LAYERS; n++)
         opaque[n] = gfx_en[n] & (pxl[n*LW +: 4] != 4'hF);
   end

   always_comb begin
      prio_addr = '0;
      prio_addr[LAYERS-1:0] = opaque;
   end

   assign prio_word = prom_p[prio_addr];

   logic [1:0]     st;
   logic [3:0]     level;
   logic           auto_in;
   logic [FCW-1:0] fcnt;
   logic           lvbl_last;
   logic           tick;
   logic           step;
   logic           req_ok;
   logic           dark;

   assign tick   = cen & lvbl_last & ~LVBL;
   assign step   = tick & (fcnt == FCW'(FADE_FRAMES - 1));
   assign req_ok = fade_req & ((st == ST_IDLE) |
                               ((st == ST_DARK) & ~fade_dir));
   assign dark      = st == ST_DARK;
   assign fade_busy = (st == ST_OUT) | (st == ST_IN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= ST_IDLE;
         level     <= 4'hF;
         auto_in   <= 1'b0;
         fcnt      <= '0;
         lvbl_last <= 1'b0;
      end else begin
         if (cen) lvbl_last <= LVBL;
         if (req_ok) fcnt <= '0;
         else if (tick) fcnt <= step ? '0 : fcnt + 1'b1;
         unique case (st)
            ST_IDLE: begin
               if (fade_req) begin
                  if (fade_dir) begin
                     st <= ST_OUT;
                  end else begin
                     st      <= ST_DARK;
                     level   <= 4'h0;
                     auto_in <= 1'b1;
                  end
               end
            end
            ST_OUT: begin
               if (step) begin
                  level <= level - 4'd1;
                  if (level == 4'd1) begin
                     st      <= ST_DARK;
                     auto_in <= 1'b0;
                  end
               end
            end
            // auto_in: entered from IDLE, so leave on the next step
            ST_DARK: begin
               if (req_ok || (step && auto_in)) begin
                  st      <= ST_IN;
                  auto_in <= 1'b0;
               end
            end
            ST_IN: begin
               if (step) begin
                  level <= level + 4'd1;
                  if (level == 4'd14) st <= ST_IDLE;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   function automatic logic [CW-1:0] scale(input logic [CW-1:0] c,
                                           input logic [3:0]    lvl);
      logic [PW-1:0] prod;
      prod = PW'(c) * PW'({1'b0, lvl} + 5'd1);
      return prod[CW+3:4];
   endfunction

   logic [LAYERS*LW-1:0] pxl_s1;
   logic [IW-1:0]        lay_s1;
   logic [SELW-1:0]      bank_s1;
   logic [3:0]           lhbl_sr;
   logic [3:0]           lvbl_sr;
   logic [LW-1:0]        sel_pix;
   logic [7:0]           pal_s2;
   logic [CW-1:0]        r_s3;
   logic [CW-1:0]        g_s3;
   logic [CW-1:0]        b_s3;

   always_comb begin
      sel_pix = pxl_s1[LW-1:0];
      for (int n = 0; n < LAYERS; n++)
         if (lay_s1 == n[IW-1:0]) sel_pix = pxl_s1[n*LW +: LW];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pxl_s1  <= '0;
         lay_s1  <= '0;
         bank_s1 <= '0;
         lhbl_sr <= '0;
         lvbl_sr <= '0;
         pal_s2  <= '0;
         r_s3    <= '0;
         g_s3    <= '0;
         b_s3    <= '0;
         red     <= '0;
         green   <= '0;
         blue    <= '0;
      end else if (cen) begin
         pxl_s1  <= pxl;
         lay_s1  <= prio_word[IW-1:0];
         bank_s1 <= prio_word[IW +: SELW];
         lhbl_sr <= {lhbl_sr[2:0], LHBL};
         lvbl_sr <= {lvbl_sr[2:0], LVBL};
         pal_s2  <= (!lhbl_sr[0] || !lvbl_sr[0]) ? 8'h00 : {bank_s1, sel_pix};
         r_s3    <= prom_r[pal_s2];
         g_s3    <= prom_g[pal_s2];
         b_s3    <= prom_b[pal_s2];
         red     <= dark ? '0 : scale(r_s3, level);
         green   <= dark ? '0 : scale(g_s3, level);
         blue    <= dark ? '0 : scale(b_s3, level);
      end
   end

   assign LHBL_dly = lhbl_sr[3];
   assign LVBL_dly = lvbl_sr[3];

endmodule

// File: tb/tb_jtgng_colmix_gen.sv
// Bench for jtgng_colmix_gen: palette model compare plus directed
// latency, blanking, PROM rewrite, fade and reset checks.
module tb_jtgng_colmix_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b0;
   logic [23:0] pxl = '0;
   logic [3:0]  gfx_en = 4'hF;
   logic        LHBL = 1'b1;
   logic        LVBL = 1'b1;
   logic [7:0]  prog_addr = '0;
   logic [1:0]  prog_sel = '0;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_din = '0;
   logic        fade_req = 1'b0;
   logic        fade_dir = 1'b0;
   logic        fade_busy;
   logic [3:0]  red, green, blue;
   logic        LHBL_dly, LVBL_dly;

   jtgng_colmix_gen #(.FADE_FRAMES(1)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen),
      .pxl(pxl), .gfx_en(gfx_en),
      .LHBL(LHBL), .LVBL(LVBL),
      .prog_addr(prog_addr), .prog_sel(prog_sel),
      .prog_we(prog_we), .prog_din(prog_din),
      .fade_req(fade_req), .fade_dir(fade_dir),
      .fade_busy(fade_busy),
      .red(red), .green(green), .blue(blue),
      .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (3) @(posedge clk);
         #1 cen = 1'b1;
         @(posedge clk);
         #1 cen = 1'b0;
      end
   end

   localparam logic [23:0] PIX_A = {6'h3F, 6'h0A, 6'h0F, 6'h01};
   localparam logic [23:0] PIX_F = {6'h3F, 6'h0B, 6'h0F, 6'h01};
   localparam logic [23:0] PIX_9 = {6'h3F, 6'h09, 6'h0F, 6'h01};

   logic [3:0]  m_r [256];
   logic [3:0]  m_g [256];
   logic [3:0]  m_b [256];
   logic [3:0]  m_p [256];
   logic [23:0] h_pxl [4];
   logic [3:0]  h_en [4];
   logic [3:0]  h_lh, h_lv;
   int          hcnt = 0;
   logic        cen_q = 1'b0;
   bit          chk_on = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;

   // history of inputs seen at each cen edge; [3] is four edges back
   always @(posedge clk) begin
      cen_q <= cen;
      if (!rst_n) begin
         hcnt <= 0;
      end else if (cen) begin
         h_pxl[0] <= pxl;
         h_pxl[1] <= h_pxl[0];
         h_pxl[2] <= h_pxl[1];
         h_pxl[3] <= h_pxl[2];
         h_en[0]  <= gfx_en;
         h_en[1]  <= h_en[0];
         h_en[2]  <= h_en[1];
         h_en[3]  <= h_en[2];
         h_lh     <= {h_lh[2:0], LHBL};
         h_lv     <= {h_lv[2:0], LVBL};
         if (hcnt < 4) hcnt <= hcnt + 1;
      end
   end

   function automatic logic [11:0] model_rgb(input logic [23:0] p,
                                             input logic [3:0]  en,
                                             input logic        lh,
                                             input logic        lv);
      int op, w, idx, bank, pa;
      pa = 0;
      if (lh && lv) begin
         op = 0;
         for (int n = 0; n < 4; n++)
            if (en[n] && ((p >> (n * 6)) & 24'hF) != 24'hF) op += (1 << n);
         w    = int'(m_p[op]);
         idx  = w % 4;
         bank = w / 4;
         pa   = bank * 64 + int'((p >> (idx * 6)) & 24'h3F);
      end
      return {m_r[pa], m_g[pa], m_b[pa]};
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step_cen(input int n = 1);
      repeat (n) begin
         do @(posedge clk); while (cen !== 1'b1);
      end
      #2;
   endtask

   task automatic prom_wr(input logic [1:0] s, input int a,
                          input logic [3:0] d);
      @(negedge clk);
      prog_sel  = s;
      prog_addr = 8'(a);
      prog_din  = d;
      prog_we   = 1'b1;
      @(negedge clk);
      prog_we = 1'b0;
      case (s)
         2'd0: m_r[a] = d;
         2'd1: m_g[a] = d;
         2'd2: m_b[a] = d;
         default: m_p[a] = d;
      endcase
   endtask

   task automatic pulse_fade(input logic d);
      @(negedge clk);
      fade_req = 1'b1;
      fade_dir = d;
      @(negedge clk);
      fade_req = 1'b0;
   endtask

   task automatic frame();
      LVBL = 1'b0;
      step_cen(2);
      LVBL = 1'b1;
      step_cen(8);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: run did not end in time");
      $fatal(1);
   end

   initial begin
      fork
         begin
            logic [11:0] e;
            forever begin
               @(negedge clk);
               if (cen_q && chk_on && rst_n && hcnt >= 4) begin
                  e = model_rgb(h_pxl[3], h_en[3], h_lh[3], h_lv[3]);
                  n_cmp++;
                  if ({red, green, blue, LHBL_dly, LVBL_dly} !==
                      {e, h_lh[3], h_lv[3]}) begin
                     n_err++;
                     $display("FAIL pipe t=%0t: got %h/%b%b expected %h/%b%b",
                              $time, {red, green, blue}, LHBL_dly, LVBL_dly,
                              e, h_lh[3], h_lv[3]);
                  end
               end
            end
         end
      join_none

      repeat (6) @(negedge clk);
      check("reset_out",
            {red, green, blue, LHBL_dly, LVBL_dly, fade_busy}, 0);
      rst_n = 1'b1;

      for (int a = 0; a < 256; a++) begin
         prom_wr(2'd0, a, 4'(a ^ (a >> 4)));
         prom_wr(2'd1, a, 4'(a + 5));
         prom_wr(2'd2, a, 4'(~a));
         prom_wr(2'd3, a, 4'(a * 5 + 9));
      end
      prom_wr(2'd3, 8'h05, 4'h6);
      prom_wr(2'd0, 8'h4A, 4'hC);

      // single opaque pixel between blanked neighbours
      pxl = PIX_A; gfx_en = 4'hF; LHBL = 1'b0; LVBL = 1'b1;
      step_cen(5);
      chk_on = 1'b1;
      LHBL = 1'b1;
      step_cen(1);
      LHBL = 1'b0;
      step_cen(2);
      check("lat_before", red, 0);
      step_cen(1);
      check("pix_a_red", red, 4'hC);
      check("pix_a_gb", {green, blue}, 8'hF5);
      check("pix_a_hb", LHBL_dly, 1);
      step_cen(1);
      check("pix_a_hb_end", LHBL_dly, 0);

      LHBL = 1'b1; gfx_en = 4'h0; pxl = {4{6'h03}};
      step_cen(4);
      check("all_off_rgb", {red, green, blue}, 12'hB8C);

      gfx_en = 4'hF; pxl = PIX_A;
      step_cen(4);
      check("pix_a_again", red, 4'hC);
      LVBL = 1'b0;
      step_cen(1);
      LVBL = 1'b1;
      step_cen(2);
      check("vb_pre", LVBL_dly, 1);
      step_cen(1);
      check("vb_rgb", {red, green, blue}, 12'h05F);
      check("vb_dly", LVBL_dly, 0);
      step_cen(1);
      check("vb_post", {LVBL_dly, red}, 5'h1C);

      // rewrite the entry on screen
      chk_on = 1'b0;
      prom_wr(2'd0, 8'h4A, 4'h3);
      step_cen(2);
      check("rewrite_red", red, 4'h3);
      check("rewrite_green", green, 4'hF);
      step_cen(2);
      chk_on = 1'b1;
      pxl = PIX_F;
      step_cen(4);
      check("nbr_4b", red, 4'hF);
      pxl = PIX_9;
      step_cen(4);
      check("nbr_49", red, 4'hD);
      pxl = PIX_A;
      step_cen(4);
      check("rewrite_hold", red, 4'h3);

      for (int i = 0; i < 48; i++) begin
         pxl    = 24'(i * 32'h9E3779 + 32'h5A5A5);
         gfx_en = 4'(i * 7 + 3);
         LHBL   = (i % 11) != 5;
         LVBL   = (i % 13) != 7;
         if (i % 4 == 0) pxl[11:6] = 6'h2F;
         step_cen(1);
      end
      pxl = PIX_F; gfx_en = 4'hF; LHBL = 1'b1; LVBL = 1'b1;
      step_cen(4);
      chk_on = 1'b0;

      // fade out, with a request in OUT that must be ignored
      step_cen(2);
      check("idle_full", red, 15);
      check("idle_busy", fade_busy, 0);
      pulse_fade(1'b1);
      check("out_busy", fade_busy, 1);
      step_cen(5);
      check("out_start", red, 15);
      for (int k = 1; k <= 15; k++) begin
         frame();
         check($sformatf("out_f%0d", k), red, k < 15 ? 15 - k : 0);
         check($sformatf("out_busy_f%0d", k), fade_busy, k < 15);
         if (k == 3) pulse_fade(1'b0);
      end
      pulse_fade(1'b1);
      frame();
      check("dark_hold", {fade_busy, red}, 0);

      pulse_fade(1'b0);
      check("in_busy", fade_busy, 1);
      for (int k = 1; k <= 15; k++) begin
         frame();
         check($sformatf("in_f%0d", k), red, k);
         check($sformatf("in_busy_f%0d", k), fade_busy, k < 15);
      end

      // from IDLE a fade-in goes through DARK for one step
      pulse_fade(1'b0);
      step_cen(5);
      check("idle_to_dark", {fade_busy, red}, 0);
      frame();
      check("dark_to_in", {fade_busy, red}, 5'h10);
      for (int k = 1; k <= 15; k++) begin
         frame();
         check($sformatf("auto_in_f%0d", k), red, k);
      end
      check("auto_in_done", fade_busy, 0);

      // reset in the middle of a fade-out
      pulse_fade(1'b1);
      repeat (8) frame();
      check("mid_fade_lvl7", red, 7);
      @(negedge clk);
      rst_n = 1'b0;
      #3;
      check("rst_mid_out",
            {red, green, blue, LHBL_dly, LVBL_dly, fade_busy}, 0);
      repeat (8) @(negedge clk);
      check("rst_mid_hold",
            {red, green, blue, LHBL_dly, LVBL_dly, fade_busy}, 0);
      rst_n = 1'b1;
      step_cen(5);
      check("post_rst_red", red, 15);
      check("post_rst_busy", fade_busy, 0);
      frame();
      check("post_rst_frame", {fade_busy, red}, 5'h0F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
